// File: rtl/multi_player_motion.sv
// Per-frame position update and wall clamping for NUM_PLAYERS players, one player per clock.
// Optional player-vs-player blocking is built only when PLAYER_COLLIDE_EN is defined.
//
// state  | meaning
// IDLE   | waiting for frame_tick_i, move_i snapshot taken on the tick
// UPDATE | writing back position and wall flags of player idx
// DONE   | one-cycle done_o pulse, then back to IDLE
module multi_player_motion #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_BITS  = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int WALL        = 8,
  parameter int PLAYER_SIZE = 16,
  parameter int STEP        = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              frame_tick_i,
  input  logic [NUM_PLAYERS*4-1:0]          move_i,
  output logic [NUM_PLAYERS*COORD_BITS-1:0] x_o,
  output logic [NUM_PLAYERS*COORD_BITS-1:0] y_o,
  output logic [NUM_PLAYERS-1:0]            collide_top_o,
  output logic [NUM_PLAYERS-1:0]            collide_bottom_o,
  output logic [NUM_PLAYERS-1:0]            collide_left_o,
  output logic [NUM_PLAYERS-1:0]            collide_right_o,
  output logic [NUM_PLAYERS-1:0]            player_hit_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              overrun_o
);

  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SW    = COORD_BITS + 2;
  localparam int XMIN  = WALL;
  localparam int XMAX  = SCREEN_W - WALL - PLAYER_SIZE;
  localparam int YMIN  = WALL;
  localparam int YMAX  = SCREEN_H - WALL - PLAYER_SIZE;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  typedef struct packed {
    logic [COORD_BITS-1:0] pos;
    logic                  lo;
    logic                  hi;
  } axis_t;

  // Opposite requests on one axis cancel: no motion and no flag on that axis.
  function automatic axis_t step_axis(input logic [COORD_BITS-1:0] cur,
                                      input logic dec, input logic inc,
                                      input int lo_lim, input int hi_lim);
    logic signed [SW-1:0] t;
    axis_t r;
    t     = $signed({2'b00, cur});
    r.pos = cur;
    r.lo  = 1'b0;
    r.hi  = 1'b0;
    if (dec != inc) begin
      t = dec ? (t - SW'(STEP)) : (t + SW'(STEP));
      if (t < SW'(lo_lim)) begin
        r.pos = COORD_BITS'(lo_lim);
        r.lo  = 1'b1;
      end else if (t > SW'(hi_lim)) begin
        r.pos = COORD_BITS'(hi_lim);
        r.hi  = 1'b1;
      end else begin
        r.pos = t[COORD_BITS-1:0];
      end
    end
    return r;
  endfunction

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [NUM_PLAYERS*4-1:0] move_snap;
  logic [COORD_BITS-1:0]   pos_x [NUM_PLAYERS];
  logic [COORD_BITS-1:0]   pos_y [NUM_PLAYERS];
  logic [3:0]              mv;
  axis_t                   ax;
  axis_t                   ay;
  logic                    blocked;

  always_comb begin
    mv = move_snap[4*idx +: 4];
    ax = step_axis(pos_x[idx], mv[2], mv[3], XMIN, XMAX);
    ay = step_axis(pos_y[idx], mv[0], mv[1], YMIN, YMAX);
  end

`ifdef PLAYER_COLLIDE_EN
  logic [NUM_PLAYERS-1:0] hit;
  logic signed [SW-1:0]   dx;
  logic signed [SW-1:0]   dy;

  // Registered positions already hold this frame's result for players below idx.
  always_comb begin
    blocked = 1'b0;
    dx      = '0;
    dy      = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (j != int'(idx)) begin
        dx = $signed({2'b00, ax.pos}) - $signed({2'b00, pos_x[j]});
        dy = $signed({2'b00, ay.pos}) - $signed({2'b00, pos_y[j]});
        if ((dx < SW'(PLAYER_SIZE)) && (dx > -SW'(PLAYER_SIZE)) &&
            (dy < SW'(PLAYER_SIZE)) && (dy > -SW'(PLAYER_SIZE)))
          blocked = 1'b1;
      end
    end
  end

  assign player_hit_o = hit;
`else
  assign blocked      = 1'b0;
  assign player_hit_o = '0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state            <= IDLE;
      idx              <= '0;
      move_snap        <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      overrun_o        <= 1'b0;
      collide_top_o    <= '0;
      collide_bottom_o <= '0;
      collide_left_o   <= '0;
      collide_right_o  <= '0;
`ifdef PLAYER_COLLIDE_EN
      hit              <= '0;
`endif
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        pos_x[k] <= COORD_BITS'(WALL + 2 * k * PLAYER_SIZE);
        pos_y[k] <= COORD_BITS'(WALL);
      end
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (frame_tick_i) begin
            move_snap <= move_i;
            idx       <= '0;
            busy_o    <= 1'b1;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          if (frame_tick_i) overrun_o <= 1'b1;
          if (!blocked) begin
            pos_x[idx] <= ax.pos;
            pos_y[idx] <= ay.pos;
          end
          collide_left_o[idx]   <= ax.lo;
          collide_right_o[idx]  <= ax.hi;
          collide_top_o[idx]    <= ay.lo;
          collide_bottom_o[idx] <= ay.hi;
`ifdef PLAYER_COLLIDE_EN
          hit[idx]              <= blocked;
`endif
          if (idx == LAST) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (frame_tick_i) overrun_o <= 1'b1;
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    x_o = '0;
    y_o = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      x_o[k*COORD_BITS +: COORD_BITS] = pos_x[k];
      y_o[k*COORD_BITS +: COORD_BITS] = pos_y[k];
    end
  end

endmodule

// File: tb/tb_multi_player_motion.sv
// Directed bench for multi_player_motion with default parameters (two players).
// The blocking scenario runs only when PLAYER_COLLIDE_EN is defined.
module tb_multi_player_motion;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        frame_tick_i;
  logic [7:0]  move_i;
  logic [19:0] x_o;
  logic [19:0] y_o;
  logic [1:0]  collide_top_o;
  logic [1:0]  collide_bottom_o;
  logic [1:0]  collide_left_o;
  logic [1:0]  collide_right_o;
  logic [1:0]  player_hit_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  multi_player_motion dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .frame_tick_i     (frame_tick_i),
    .move_i           (move_i),
    .x_o              (x_o),
    .y_o              (y_o),
    .collide_top_o    (collide_top_o),
    .collide_bottom_o (collide_bottom_o),
    .collide_left_o   (collide_left_o),
    .collide_right_o  (collide_right_o),
    .player_hit_o     (player_hit_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .overrun_o        (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full frame: tick for one cycle, then wait (bounded) for done_o.
  task automatic run_frame(input logic [7:0] mv);
    int seen;
    seen = 0;
    @(negedge clk_i);
    move_i       = mv;
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (done_o) seen = 1;
      else @(negedge clk_i);
    end
    check("frame_done", seen, 1);
  endtask

  initial begin
    reset_ni     = 1'b0;
    frame_tick_i = 1'b0;
    move_i       = '0;
    repeat (2) @(negedge clk_i);
    check("rst_x", x_o, {10'd40, 10'd8});
    check("rst_y", y_o, {10'd8, 10'd8});
    check("rst_flags", {collide_top_o, collide_bottom_o, collide_left_o, collide_right_o}, 0);
    check("rst_hit", player_hit_o, 0);
    check("rst_ctl", {busy_o, done_o, overrun_o}, 0);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Latency: player 0 moves right, player 1 idle
    @(negedge clk_i);
    move_i = 8'h08; frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    check("t1_busy", busy_o, 1);
    check("t1_done", done_o, 0);
    @(negedge clk_i);
    check("t2_x0", x_o[9:0], 10);
    check("t2_busy", busy_o, 1);
    check("t2_done", done_o, 0);
    @(negedge clk_i);
    check("t3_done", done_o, 1);
    check("t3_busy", busy_o, 0);
    check("t3_x1", x_o[19:10], 40);
    check("t3_y", y_o, {10'd8, 10'd8});
    @(negedge clk_i);
    check("t4_ctl", {busy_o, done_o, overrun_o}, 0);

    // Top wall: flag lasts one frame; opposing bits cancel
    run_frame(8'h01);
    check("top_y0", y_o[9:0], 8);
    check("top_flag", collide_top_o, 2'b01);
    run_frame(8'h00);
    check("top_clear", collide_top_o, 0);
    run_frame(8'h03);
    check("updown_y0", y_o[9:0], 8);
    check("updown_flags", {collide_top_o[0], collide_bottom_o[0]}, 0);

    // Right wall: reach 614, then 616 exactly (no flag), then clamp (flag)
    for (int f = 0; f < 302; f++) run_frame(8'h08);
    check("walk_x0", x_o[9:0], 614);
    run_frame(8'h08);
    check("edge_x0", x_o[9:0], 616);
    check("edge_flag", collide_right_o[0], 0);
    run_frame(8'h08);
    check("clamp_x0", x_o[9:0], 616);
    check("clamp_flag", collide_right_o[0], 1);

    // Overrun: extra ticks during UPDATE and DONE are ignored
    @(negedge clk_i);
    move_i = 8'h04; frame_tick_i = 1'b1;
    @(negedge clk_i);
    move_i = 8'h08;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    check("ovr_x0", x_o[9:0], 614);
    @(negedge clk_i);
    check("ovr_done", done_o, 1);
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    check("ovr_flag", overrun_o, 1);
    repeat (3) @(negedge clk_i);
    check("ovr_norestart", {busy_o, done_o}, 0);
    check("ovr_hold", overrun_o, 1);
    check("ovr_x0_final", x_o[9:0], 614);

    // Reset mid-sequence
    @(negedge clk_i);
    move_i = 8'h04; frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    reset_ni = 1'b0;
    #1;
    check("mid_x0", x_o[9:0], 8);
    check("mid_ctl", {busy_o, done_o, overrun_o}, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("post_x", x_o, {10'd40, 10'd8});
    check("post_busy", busy_o, 0);

`ifdef PLAYER_COLLIDE_EN
    for (int f = 0; f < 8; f++) run_frame(8'h40);
    check("col_x1_24", x_o[19:10], 24);
    check("col_nohit", player_hit_o, 0);
    run_frame(8'h40);
    check("col_blocked_x1", x_o[19:10], 24);
    check("col_hit", player_hit_o, 2'b10);
    run_frame(8'h80);
    check("col_free_x1", x_o[19:10], 26);
    check("col_hit_clear", player_hit_o, 0);
`else
    run_frame(8'h40);
    check("nocol_x1", x_o[19:10], 38);
    check("nocol_hit", player_hit_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
